seq_ctrl: RTL and testbench

- Program sequencer for the 18-bit-instruction processor core.
- Owns the program counter and drives the program-memory address each cycle.
- Resolves control-flow instructions from the fetched word: BRZ, JMP-as-call, RET and JMP 0 (return to idle).
- Implements the start/ready handshake and sits between the program ROM, the register file (zero test) and the execute datapath.

---
 rtl/seq_pkg.sv | 34 +++
 rtl/ret_stack.sv | 50 +++++
 rtl/seq_ctrl.sv | 120 ++++++++++++
 tb/tb_seq_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: widths, control-flow opcodes,
// FSM state encoding and instruction field slicers.
package seq_pkg;

    localparam int unsigned AW = 13;
    localparam int unsigned IW = 18;

    localparam logic [4:0] OP_BRZ = 5'b11000;
    localparam logic [4:0] OP_JMP = 5'b11010;
    localparam logic [4:0] OP_RET = 5'b11100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    function automatic logic [4:0] opcode(input logic [IW-1:0] i);
        return i[17:13];
    endfunction

    function automatic logic [8:0] offset9(input logic [IW-1:0] i);
        return i[12:4];
    endfunction

    function automatic logic [12:0] target13(input logic [IW-1:0] i);
        return i[12:0];
    endfunction

    function automatic logic [3:0] reg4(input logic [IW-1:0] i);
        return i[3:0];
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; clear has priority over push/pop, and push to a full
// or pop from an empty stack is ignored.
module ret_stack #(
    parameter int unsigned DW    = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [DW-1:0]              din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DW-1:0]              top
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_top_idx;

    assign full      = (r_cnt == CW'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign w_top_idx = r_cnt[PW-1:0] - PW'(1);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (push && !full) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            r_mem[r_cnt[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Program sequencer: owns the PC, resolves BRZ / JMP-call / RET / JMP 0 in a
// single cycle and runs the start/ready handshake with a sticky stack fault.
module seq_ctrl #(
    parameter int unsigned AW          = seq_pkg::AW,
    parameter int unsigned IW          = seq_pkg::IW,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    output logic                            ready,
    output logic                            fault,
    output logic [AW-1:0]                   padr,
    input  logic [IW-1:0]                   instr,
    input  logic                            stall,
    output logic                            issue,
    output logic [3:0]                      brz_reg,
    input  logic                            rf_zero,
    output logic [$clog2(STACK_DEPTH):0]    sp
);

    import seq_pkg::*;

    state_t        r_state, w_next_state;
    logic [AW-1:0] r_pc, w_next_pc, w_pc_inc, w_brz_off, w_tgt, w_top;
    logic          r_fault;
    logic          w_push, w_pop, w_clear, w_full, w_empty;

    assign w_pc_inc  = r_pc + AW'(1);
    assign w_brz_off = AW'($signed(offset9(instr)));
    assign w_tgt     = AW'(target13(instr));

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE, FAULT: begin
                if (start) begin
                    w_next_state = RUN;
                    w_next_pc    = AW'(1);
                    w_clear      = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    case (opcode(instr))
                        OP_BRZ: w_next_pc = rf_zero ? (r_pc + w_brz_off) : w_pc_inc;
                        OP_JMP: begin
                            if (w_tgt == '0) begin
                                w_next_state = IDLE;
                                w_next_pc    = '0;
                                w_clear      = 1'b1;
                            end else if (!w_full) begin
                                w_push    = 1'b1;
                                w_next_pc = w_tgt;
                            end else begin
                                w_next_state = FAULT;
                            end
                        end
                        OP_RET: begin
                            if (!w_empty) begin
                                w_pop     = 1'b1;
                                w_next_pc = w_top;
                            end else begin
                                w_next_state = FAULT;
                            end
                        end
                        default: w_next_pc = w_pc_inc;
                    endcase
                    // Any path that lands on address 0 ends the program.
                    if (w_next_state == RUN && w_next_pc == '0) begin
                        w_next_state = IDLE;
                        w_push       = 1'b0;
                        w_pop        = 1'b0;
                        w_clear      = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_fault <= (w_next_state == FAULT);
        end
    end

    ret_stack #(
        .DW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .clear   (w_clear),
        .din     (w_pc_inc),
        .full    (w_full),
        .empty   (w_empty),
        .count   (sp),
        .top     (w_top)
    );

    assign padr    = r_pc;
    assign ready   = (r_state == IDLE);
    assign issue   = (r_state == RUN) && !stall;
    assign fault   = r_fault;
    assign brz_reg = reg4(instr);

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: a ROM model feeds instr from padr; per-cycle stimulus and
// hand-derived expected observations flow through a scoreboard queue.
module tb_seq_ctrl;

    localparam int unsigned AW = 13;
    localparam int unsigned IW = 18;
    localparam int unsigned SD = 4;

    logic          clk = 1'b0;
    logic          reset_n, start, stall, rf_zero;
    logic          ready, fault, issue;
    logic [AW-1:0] padr;
    logic [IW-1:0] instr;
    logic [3:0]    brz_reg;
    logic [2:0]    sp;

    logic [IW-1:0] rom [8192];

    typedef struct packed {
        logic [AW-1:0] padr;
        logic [2:0]    sp;
        logic          ready;
        logic          issue;
        logic          fault;
    } obs_t;

    typedef struct packed {
        logic start;
        logic stall;
        logic rz;
        obs_t exp;
    } step_t;

    step_t steps[$];
    obs_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;
    assign instr = rom[padr];

    seq_ctrl #(.AW(AW), .IW(IW), .STACK_DEPTH(SD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .ready   (ready),
        .fault   (fault),
        .padr    (padr),
        .instr   (instr),
        .stall   (stall),
        .issue   (issue),
        .brz_reg (brz_reg),
        .rf_zero (rf_zero),
        .sp      (sp)
    );

    function automatic logic [IW-1:0] f_jmp(input logic [12:0] t);
        return {5'b11010, t};
    endfunction
    function automatic logic [IW-1:0] f_brz(input logic [8:0] off, input logic [3:0] r);
        return {5'b11000, off, r};
    endfunction
    function automatic logic [IW-1:0] f_ret();
        return {5'b11100, 13'd0};
    endfunction

    function automatic obs_t cur();
        return {padr, sp, ready, issue, fault};
    endfunction
    function automatic obs_t ex_run(input logic [AW-1:0] pc, input logic [2:0] s);
        return {pc, s, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic obs_t ex_hold(input logic [AW-1:0] pc, input logic [2:0] s);
        return {pc, s, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic obs_t ex_fault(input logic [AW-1:0] pc, input logic [2:0] s);
        return {pc, s, 1'b0, 1'b0, 1'b1};
    endfunction
    function automatic obs_t ex_idle();
        return {13'd0, 3'd0, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic void add(input logic st, input logic sl, input logic rz, input obs_t e);
        steps.push_back({st, sl, rz, e});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 8192; a++) rom[a] = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        rf_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        step_t s;
        clear_rom();
        do_reset();
        o = cur();
        n_checks++;
        if (o !== ex_idle()) $display("FAIL reset_state: got %h want %h", o, ex_idle());
        else n_pass++;
        add(1'b0, 1'b1, 1'b0, ex_idle());
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd2, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd3, 3'd0));
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL reset_start step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_call_ret();
        obs_t o, e;
        step_t s;
        clear_rom();
        rom[14]  = f_jmp(13'd200);
        rom[207] = f_ret();
        rom[16]  = f_jmp(13'd0);
        do_reset();
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        for (int a = 2; a <= 14; a++) add(a == 5, 1'b0, 1'b0, ex_run(13'(a), 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd200, 3'd1));
        for (int a = 201; a <= 207; a++) add(1'b0, 1'b0, 1'b0, ex_run(13'(a), 3'd1));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd15, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd16, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_idle());
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL call_ret step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        start = 1'b0;
    endtask

    task automatic test_brz();
        obs_t o, e;
        step_t s;
        clear_rom();
        rom[0]   = f_brz(9'd0, 4'd9);
        rom[1]   = f_brz(9'd199, 4'd0);
        rom[200] = f_brz(9'd6, 4'd2);
        rom[205] = f_brz(9'b111111101, 4'd5);
        rom[207] = f_brz(9'h1F9, 4'd0);
        rom[208] = f_brz(9'h130, 4'd1);
        do_reset();
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_run(13'd200, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd201, 3'd0));
        for (int a = 202; a <= 205; a++) add(1'b0, 1'b0, 1'b1, ex_run(13'(a), 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_run(13'd202, 3'd0));
        for (int a = 203; a <= 205; a++) add(1'b0, 1'b0, 1'b0, ex_run(13'(a), 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd206, 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_run(13'd207, 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_run(13'd200, 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_run(13'd206, 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_run(13'd207, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd208, 3'd0));
        add(1'b0, 1'b0, 1'b1, ex_idle());
        add(1'b0, 1'b0, 1'b1, ex_idle());
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL brz step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        n_checks++;
        if (brz_reg !== 4'd9) $display("FAIL brz_reg: got %0d want 9", brz_reg);
        else n_pass++;
        rf_zero = 1'b0;
    endtask

    task automatic test_overflow();
        obs_t o, e;
        step_t s;
        clear_rom();
        rom[1]  = f_jmp(13'd10);
        rom[10] = f_jmp(13'd20);
        rom[20] = f_jmp(13'd30);
        rom[30] = f_jmp(13'd40);
        rom[40] = f_jmp(13'd50);
        do_reset();
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd10, 3'd1));
        add(1'b1, 1'b0, 1'b0, ex_run(13'd20, 3'd2));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd30, 3'd3));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd40, 3'd4));
        add(1'b0, 1'b0, 1'b0, ex_fault(13'd40, 3'd4));
        add(1'b0, 1'b1, 1'b0, ex_fault(13'd40, 3'd4));
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd10, 3'd1));
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL overflow step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_underflow_wrap();
        obs_t o, e;
        step_t s;
        clear_rom();
        rom[1] = f_ret();
        do_reset();
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_fault(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_fault(13'd1, 3'd0));
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_fault(13'd1, 3'd0));
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL underflow step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        rom[1] = f_jmp(13'h1FFF);
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'h1FFF, 3'd1));
        add(1'b0, 1'b0, 1'b0, ex_idle());
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL wrap step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        start = 1'b0;
    endtask

    task automatic test_stall_idle();
        obs_t o, e;
        step_t s;
        clear_rom();
        rom[5]   = f_jmp(13'd300);
        rom[300] = f_jmp(13'd0);
        do_reset();
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        for (int a = 2; a <= 5; a++) add(1'b0, 1'b0, 1'b0, ex_run(13'(a), 3'd0));
        for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, ex_hold(13'd5, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd300, 3'd1));
        add(1'b0, 1'b0, 1'b0, ex_idle());
        add(1'b1, 1'b1, 1'b0, ex_hold(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd2, 3'd0));
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL stall_idle step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        step_t s;
        clear_rom();
        rom[1]  = f_jmp(13'd50);
        rom[50] = f_jmp(13'd60);
        do_reset();
        add(1'b1, 1'b0, 1'b0, ex_run(13'd1, 3'd0));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd50, 3'd1));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd60, 3'd2));
        add(1'b0, 1'b0, 1'b0, ex_run(13'd61, 3'd2));
        for (int i = 0; steps.size() > 0; i++) begin
            s = steps.pop_front();
            start = s.start; stall = s.stall; rf_zero = s.rz;
            sb.push_back(s.exp);
            tick();
            e = sb.pop_front();
            o = cur();
            n_checks++;
            if (o !== e) $display("FAIL async_pre step %0d: got %h want %h", i, o, e);
            else n_pass++;
        end
        start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        o = cur();
        n_checks++;
        if (o !== ex_idle()) $display("FAIL async_reset: got %h want %h", o, ex_idle());
        else n_pass++;
        tick();
        reset_n = 1'b1;
        tick();
        o = cur();
        n_checks++;
        if (o !== ex_idle()) $display("FAIL async_release: got %h want %h", o, ex_idle());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_brz();
        test_overflow();
        test_underflow_wrap();
        test_stall_idle();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
